// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential carry-save / carry-select multiplier.
//   state_t    : controller states (exposed on the top-level dbg_state port)
//   latency()  : cycles from operand accept to OUT_VALID for a given M, R
//   nblk()     : number of carry-select blocks for a W-bit adder
//   params_ok(): legality of an (N, M, R, BLK) combination
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int latency(input int m, input int r);
    return m / r + 1;
  endfunction

  function automatic int nblk(input int w, input int blk);
    return (w + blk - 1) / blk;
  endfunction

  function automatic bit params_ok(input int n, input int m, input int r, input int blk);
    return (n >= 2) && (m >= 2) && (r >= 1) && (r <= m) && ((m % r) == 0) &&
           (blk >= 1) && (blk <= n + m);
  endfunction

endpackage

// File: rtl/seq_mult_csa_csel_if.sv
// Operand / result bus of the sequential multiplier.
// Handshake: a beat transfers on a rising CLK edge where the source's VALID
// and the sink's READY are both high; the source holds its payload stable
// while VALID is high and READY is low.
//   master : operand producer and result consumer (drives IN_*, SGN, OUT_READY)
//   slave  : the multiplier (drives IN_READY, OUT_VALID, P, BUSY)
interface seq_mult_csa_csel_if #(
  parameter int N = 8,
  parameter int M = 4
);
  logic           IN_VALID;
  logic           IN_READY;
  logic [N-1:0]   IN1;
  logic [M-1:0]   IN2;
  logic           SGN;
  logic           OUT_VALID;
  logic           OUT_READY;
  logic [N+M-1:0] P;
  logic           BUSY;

  modport master (
    output IN_VALID, IN1, IN2, SGN, OUT_READY,
    input  IN_READY, OUT_VALID, P, BUSY
  );

  modport slave (
    input  IN_VALID, IN1, IN2, SGN, OUT_READY,
    output IN_READY, OUT_VALID, P, BUSY
  );
endinterface

// File: rtl/mult_csel_adder.sv
// Combinational W-bit carry-select adder, S = (X + Y) mod 2^W.
// Blocks of BLK bits from the LSB; the top block is narrower when BLK does
// not divide W. Block 0 ripples with carry-in 0; every later block forms
// both carry-in sums and picks one with the carry out of the block below.
// The carry out of the top block is dropped.
//   X, Y : W-bit addends
//   S    : W-bit sum
module mult_csel_adder
  import seq_mult_pkg::*;
#(
  parameter int W   = 12,
  parameter int BLK = 3
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic [W-1:0] S
);

  localparam int NB = nblk(W, BLK);

  for (genvar b = 0; b < NB; b++) begin : g_blk
    localparam int LO = b * BLK;
    localparam int BW = ((W - LO) < BLK) ? (W - LO) : BLK;
    // Non-top blocks carry one extra bit: their carry out.
    localparam int RW = (b == NB - 1) ? BW : BW + 1;

    logic [RW-1:0] res;

    if (b == 0) begin : g_ripple
      assign res = RW'(X[LO +: BW]) + RW'(Y[LO +: BW]);
    end else begin : g_sel
      logic [RW-1:0] r0;
      logic [RW-1:0] r1;
      assign r0  = RW'(X[LO +: BW]) + RW'(Y[LO +: BW]);
      assign r1  = RW'(X[LO +: BW]) + RW'(Y[LO +: BW]) + RW'(1);
      // The block below is never the top block, so it is full width and
      // its carry out sits at bit BLK of its result.
      assign res = g_blk[b-1].res[BLK] ? r1 : r0;
    end

    assign S[LO +: BW] = res[BW-1:0];
  end

endmodule

// File: rtl/seq_mult_csa_csel.sv
// Sequential N x M multiplier, signed or unsigned per transaction.
// R multiplier bits are folded per cycle into a carry-save sum/carry pair;
// one final cycle resolves the pair with a carry-select adder into P.
// Latency accept -> OUT_VALID is M/R+1 edges; one product per M/R+2 cycles
// when the consumer is always ready.
//   CLK, RST_N : clock (rising edge), asynchronous active-low reset
//   bus        : operand/result handshake bus (slave side)
//   dbg_state  : current controller state
module seq_mult_csa_csel
  import seq_mult_pkg::*;
#(
  parameter int N   = 8,
  parameter int M   = 4,
  parameter int R   = 2,
  parameter int BLK = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  seq_mult_csa_csel_if.slave  bus,
  output state_t              dbg_state
);

  if (!params_ok(N, M, R, BLK)) begin : g_param_err
    $error("seq_mult_csa_csel: illegal combination of N, M, R, BLK");
  end

  localparam int W     = N + M;
  localparam int STEPS = M / R;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [W-1:0] ONE_W = W'(1);
  // Baugh-Wooley constant: the complemented partial-product bits each hide
  // a -2^i term; summed, those terms equal 2^(W-1) + 2^(N-1) + 2^(M-1) mod 2^W.
  localparam logic [W-1:0] BW_CORR = (ONE_W << (W - 1)) + (ONE_W << (N - 1)) +
                                     (ONE_W << (M - 1));
  localparam logic [N-1:0] MSB_MASK = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] LOW_MASK = ~MSB_MASK;

  state_t         state_q,     state_d;
  logic [CW-1:0]  cnt_q,       cnt_d;
  logic [N-1:0]   a_q,         a_d;
  logic [M-1:0]   b_q,         b_d;      // shifted right R bits per step
  logic           sgn_q,       sgn_d;
  logic [W-1:0]   sum_q,       sum_d;
  logic [W-1:0]   cry_q,       cry_d;
  logic [W-1:0]   p_q,         p_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q,      busy_d;
  logic           idle_rdy_q,  idle_rdy_d;

  logic           in_ready;
  logic           accept;
  logic           last_step;
  logic [W-1:0]   csa_sum;
  logic [W-1:0]   csa_cry;
  logic [W-1:0]   add_s;

  // Scratch for the carry-save rows.
  logic [N-1:0]   pp;
  logic [W-1:0]   row;
  logic [W-1:0]   maj;

  // Ready while idle (from the first edge after reset) and, in DONE,
  // exactly when the result is being taken so a new accept chains in.
  assign in_ready  = idle_rdy_q | ((state_q == DONE) & bus.OUT_READY);
  assign accept    = bus.IN_VALID & in_ready;
  assign last_step = (cnt_q == CW'(STEPS - 1));

  // ---------------------------------------------------------------------
  // R carry-save rows per cycle. Row i uses multiplier bit cnt*R+i, which
  // is b_q[i] because b_q is shifted down R bits each step.
  // ---------------------------------------------------------------------
  always_comb begin
    csa_sum = sum_q;
    csa_cry = cry_q;
    pp      = '0;
    row     = '0;
    maj     = '0;
    for (int i = 0; i < R; i++) begin
      pp = a_q & {N{b_q[i]}};
      if (sgn_q) begin
        // Multiplier-MSB row: complement all but the multiplicand MSB.
        // Other rows: complement only the multiplicand-MSB column.
        if (last_step && (i == R - 1)) pp = pp ^ LOW_MASK;
        else                           pp = pp ^ MSB_MASK;
      end
      row     = W'(pp) << (int'(cnt_q) * R + i);
      maj     = (csa_sum & csa_cry) | (csa_sum & row) | (csa_cry & row);
      csa_sum = csa_sum ^ csa_cry ^ row;
      csa_cry = maj << 1;
    end
  end

  mult_csel_adder #(
    .W   (W),
    .BLK (BLK)
  ) u_final_add (
    .X (sum_q),
    .Y (cry_q),
    .S (add_s)
  );

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sgn_d       = sgn_q;
    sum_d       = sum_q;
    cry_d       = cry_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: ;
      ACCUM: begin
        sum_d = csa_sum;
        cry_d = csa_cry;
        b_d   = b_q >> R;
        cnt_d = cnt_q + CW'(1);
        if (last_step) state_d = FINAL;
      end
      FINAL: begin
        p_d         = add_s;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (bus.OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accept is only possible in IDLE or in DONE during the result handshake.
    if (accept) begin
      a_d     = bus.IN1;
      b_d     = bus.IN2;
      sgn_d   = bus.SGN;
      sum_d   = '0;
      cry_d   = bus.SGN ? BW_CORR : '0;
      cnt_d   = '0;
      state_d = ACCUM;
    end
  end

  assign busy_d     = (state_d == ACCUM) || (state_d == FINAL);
  assign idle_rdy_d = (state_d == IDLE);

  // ---------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sgn_q       <= 1'b0;
      sum_q       <= '0;
      cry_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      idle_rdy_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sgn_q       <= sgn_d;
      sum_q       <= sum_d;
      cry_q       <= cry_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      idle_rdy_q  <= idle_rdy_d;
    end
  end

  assign bus.IN_READY  = in_ready;
  assign bus.OUT_VALID = out_valid_q;
  assign bus.P         = p_q;
  assign bus.BUSY      = busy_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_seq_mult_csa_csel.sv
module tb_seq_mult_csa_csel;
  import seq_mult_pkg::*;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST_N;
  logic rst_sw_n;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    rst_sw_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1 rst_sw_n = 1'b1;
  end

  // ---------------- default-parameter DUT ----------------
  seq_mult_csa_csel_if #(.N(8), .M(4)) bus ();
  state_t dbg_state;

  seq_mult_csa_csel #(.N(8), .M(4), .R(2), .BLK(3)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];
  int out_cyc_q[$];

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.OUT_VALID && bus.OUT_READY) begin
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else                   chk("product", longint'(bus.P), longint'(exp_q.pop_front()));
      out_cyc_q.push_back(cyc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [3:0] b, input logic s,
                      input logic [11:0] e);
    int w;
    w = 0;
    bus.IN1 = a; bus.IN2 = b; bus.SGN = s; bus.IN_VALID = 1'b1;
    @(negedge CLK);
    while (!bus.IN_READY && w < 100) begin
      @(negedge CLK);
      w++;
    end
    if (w >= 100) chk("accept_timeout", 0, 1);
    else          exp_q.push_back(e);
    @(posedge CLK);
    #1 bus.IN_VALID = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge CLK);
      #1;
      n++;
    end while (!bus.OUT_VALID && n < 20);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 50) begin
      @(posedge CLK);
      w++;
    end
    chk("drain", exp_q.size(), 0);
    #1;
  endtask

  // Directed vectors: {IN1, IN2, SGN, expected P}
  localparam int NV = 10;
  logic [7:0]  va [NV] = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'hFF, 8'h80, 8'hA5, 8'h80, 8'h7F, 8'hFF};
  logic [3:0]  vb [NV] = '{4'h8,  4'hF,  4'hA,  4'h9,  4'h8,  4'h7,  4'h3,  4'h8,  4'hF,  4'hF};
  logic        vs [NV] = '{1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
  logic [11:0] vp [NV] = '{12'h400, 12'hF81, 12'h000, 12'h000, 12'h008,
                           12'hC80, 12'h1EF, 12'h400, 12'h771, 12'h001};

  // ---------------- parameter sweep instances ----------------
  localparam int SW_CNT = 2000;
  localparam int SW_N [3] = '{16, 8, 12};
  localparam int SW_M [3] = '{8, 4, 6};
  localparam int SW_R [3] = '{4, 1, 6};
  localparam int SW_B [3] = '{4, 1, 5};

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int GN = SW_N[g];
    localparam int GM = SW_M[g];
    localparam int GR = SW_R[g];
    localparam int GW = GN + GM;

    seq_mult_csa_csel_if #(.N(GN), .M(GM)) sif ();
    state_t sdbg;
    logic [GW-1:0] sexp_q[$];
    int sacc_q[$];
    logic done = 1'b0;

    seq_mult_csa_csel #(.N(GN), .M(GM), .R(GR), .BLK(SW_B[g])) u_sw (
      .CLK       (CLK),
      .RST_N     (rst_sw_n),
      .bus       (sif),
      .dbg_state (sdbg)
    );

    initial begin : drv
      int w;
      longint sa, sb;
      logic [GN-1:0] a;
      logic [GM-1:0] b;
      sif.IN_VALID = 1'b0; sif.IN1 = '0; sif.IN2 = '0; sif.SGN = 1'b0;
      sif.OUT_READY = 1'b1;
      @(posedge rst_sw_n);
      @(posedge CLK);
      #1;
      for (int i = 0; i < SW_CNT; i++) begin
        a = GN'($urandom);
        b = GM'($urandom);
        for (int s = 0; s < 2; s++) begin
          sa = (s != 0) ? longint'($signed(a)) : longint'(a);
          sb = (s != 0) ? longint'($signed(b)) : longint'(b);
          sexp_q.push_back(GW'(sa * sb));
          sif.IN1 = a; sif.IN2 = b; sif.SGN = (s != 0); sif.IN_VALID = 1'b1;
          w = 0;
          @(negedge CLK);
          while (!sif.IN_READY && w < 50) begin
            @(negedge CLK);
            w++;
          end
          @(posedge CLK);
          #1;
          sacc_q.push_back(cyc);
        end
      end
      sif.IN_VALID = 1'b0;
      w = 0;
      while (sexp_q.size() != 0 && w < 100) begin
        @(posedge CLK);
        w++;
      end
      chk($sformatf("sweep%0d_drain", g), sexp_q.size(), 0);
      done = 1'b1;
    end

    always @(negedge CLK) begin
      if (sif.OUT_VALID && sif.OUT_READY) begin
        if (sexp_q.size() == 0) chk($sformatf("sweep%0d_unexpected", g), 1, 0);
        else begin
          chk($sformatf("sweep%0d_product", g), longint'(sif.P), longint'(sexp_q.pop_front()));
          chk($sformatf("sweep%0d_latency", g), cyc - sacc_q.pop_front(), latency(GM, GR));
        end
      end
    end
  end

  // ---------------- main directed sequence ----------------
  initial begin
    int lat;
    int seen;
    int w;
    bus.IN_VALID = 1'b0; bus.IN1 = '0; bus.IN2 = '0; bus.SGN = 1'b0;
    bus.OUT_READY = 1'b1;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", bus.OUT_VALID, 0);
    chk("rst_p", bus.P, 0);
    chk("rst_busy", bus.BUSY, 0);
    chk("rst_state", dbg_state, IDLE);
    @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("in_ready_after_rst", bus.IN_READY, 1);

    // Unsigned max operands, latency
    send(8'hFF, 4'hF, 1'b0, 12'hEF1);
    wait_out(lat);
    chk("latency_unsigned", lat, 3);
    drain();

    // Signed extremes and mixed vectors
    for (int i = 0; i < NV; i++) begin
      send(va[i], vb[i], vs[i], vp[i]);
      wait_out(lat);
      chk("latency_vec", lat, 3);
      drain();
    end

    // Backpressure
    bus.OUT_READY = 1'b0;
    send(8'h12, 4'h3, 1'b0, 12'h036);
    wait_out(lat);
    chk("bp_latency", lat, 3);
    bus.IN1 = 8'h55; bus.IN2 = 4'h5; bus.SGN = 1'b0; bus.IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("bp_out_valid", bus.OUT_VALID, 1);
      chk("bp_p_stable", bus.P, 12'h036);
      chk("bp_in_ready", bus.IN_READY, 0);
      chk("bp_state", dbg_state, DONE);
    end
    @(posedge CLK);
    #1;
    bus.IN_VALID = 1'b0;
    bus.OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    chk("bp_release_valid", bus.OUT_VALID, 0);
    chk("bp_release_state", dbg_state, IDLE);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Back-to-back streaming
    out_cyc_q.delete();
    send(8'h03, 4'h5, 1'b0, 12'h00F);
    send(8'h10, 4'h2, 1'b0, 12'h020);
    send(8'hFF, 4'h1, 1'b0, 12'h0FF);
    drain();
    chk("b2b_count", out_cyc_q.size(), 3);
    if (out_cyc_q.size() == 3) begin
      chk("b2b_gap1", out_cyc_q[1] - out_cyc_q[0], 4);
      chk("b2b_gap2", out_cyc_q[2] - out_cyc_q[1], 4);
    end

    // Reset during ACCUM
    @(posedge CLK);
    #1;
    bus.IN1 = 8'h55; bus.IN2 = 4'h5; bus.SGN = 1'b0; bus.IN_VALID = 1'b1;
    @(posedge CLK);
    #1 bus.IN_VALID = 1'b0;
    chk("midop_state", dbg_state, ACCUM);
    chk("midop_busy", bus.BUSY, 1);
    #2 RST_N = 1'b0;
    #1;
    chk("midop_rst_out_valid", bus.OUT_VALID, 0);
    chk("midop_rst_p", bus.P, 0);
    chk("midop_rst_busy", bus.BUSY, 0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(posedge CLK);
    #1 chk("midop_in_ready", bus.IN_READY, 1);
    seen = 0;
    repeat (8) begin
      @(negedge CLK);
      if (bus.OUT_VALID) seen++;
    end
    chk("midop_no_output", seen, 0);
    @(posedge CLK);
    #1;

    // Normal operation after reset
    send(8'h0C, 4'h3, 1'b0, 12'h024);
    wait_out(lat);
    chk("post_rst_latency", lat, 3);
    drain();

    // Wait for the parameter sweeps
    w = 0;
    while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done) && w < 40000) begin
      @(posedge CLK);
      w++;
    end
    chk("sweep_complete", (g_sw[0].done && g_sw[1].done && g_sw[2].done), 1);
    chk("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_csa_csel.md
Name: seq_mult_csa_csel

Overview:
- Parametrised multi-cycle multiplier: N-bit multiplicand × M-bit multiplier → (N+M)-bit product.
- Multiplier bits are consumed R per cycle into carry-save sum/carry registers using the simple AND-gate partial products of the combinational array family.
- One final cycle resolves the carry-save pair with a blocked carry-select adder.
- Adds over the fixed 8×4 unsigned array: valid/ready handshakes, per-transaction signed/unsigned mode, and configurable width/throughput trade-off. It sits between the operand and result stages of the datapath.

Parameters:
- N, 8: multiplicand (IN1) width, ≥2.
- M, 4: multiplier (IN2) width, ≥2. M mod R must be 0.
- R, 2: multiplier bits retired per accumulate cycle, 1..M.
- BLK, 3: carry-select block width of the final adder, 1..N+M.

Ports:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operands valid.
- IN_READY  out  1  block can accept operands.
- IN1  in  N  multiplicand.
- IN2  in  M  multiplier.
- SGN  in  1  0 = unsigned, 1 = two's-complement signed (both operands); sampled with operands.
- OUT_VALID  out  1  product valid.
- OUT_READY  in  1  consumer accepts product.
- P  out  N+M  product.
- BUSY  out  1  high in ACCUM or FINAL.

Behaviour:
- Reset, asynchronous on RST_N low:
  - state=IDLE, OUT_VALID=0, P=0, BUSY=0.
  - Sum/carry/count registers cleared.
  - IN_READY=1 from the first edge after reset release.
- Reset mid-operation aborts the transaction; no OUT_VALID is produced for it.
- Acceptance: on a cycle with IN_VALID & IN_READY, IN1/IN2/SGN are latched. Operand changes after acceptance have no effect.
- FSM:
  - IDLE: IN_READY=1. Accept → ACCUM, count=0.
  - ACCUM:
    - Each cycle adds R partial products (IN1 & IN2[k], shifted by k) into the carry-save pair via full/half-adder rows, then count+1.
    - When count = M/R−1 → FINAL.
  - FINAL: carry-select add of sum+carry over N+M bits, registered into P. OUT_VALID=1 → DONE.
  - DONE:
    - P and OUT_VALID held stable until OUT_READY.
    - On OUT_READY: OUT_VALID drops next cycle. IN_READY = OUT_READY in DONE, so a new accept in that same cycle goes directly to ACCUM.
- Latency: accept at edge t → OUT_VALID high after edge t+M/R+1 (default: 3 cycles).
- Throughput: one product per M/R+2 cycles with OUT_READY held high.
- Arithmetic:
  - P = (IN1 × IN2) mod 2^(N+M), interpreted per SGN.
  - SGN=1 uses Baugh-Wooley: the partial product of the multiplier MSB is negated, and the multiplicand MSB column is complemented with a correction constant.
  - Result is exact for the full range, including −2^(N−1) × −2^(M−1).
  - The final adder's carry-out beyond bit N+M−1 is discarded.
- Carry-select adder: blocks of BLK bits from LSB; the last block is narrower if BLK does not divide N+M. Block 0 is a ripple block with carry-in 0. Every other block computes both carry-in cases and muxes on the previous block's carry.
- IN_VALID while BUSY: ignored (IN_READY=0), no state change.
- OUT_READY while OUT_VALID=0: ignored.

Decomposition:
- Package seq_mult_pkg:
  - state enum {IDLE, ACCUM, FINAL, DONE};
  - function latency(M,R) = M/R+1;
  - function nblk(W,BLK) = ceil(W/BLK);
  - parameter legality checks (M%R==0) as elaboration assertions.
- Sub-module mult_csel_adder: combinational W-bit carry-select adder, parameters W and BLK, ports X, Y → S. Instantiated once in FINAL, and reusable by combinational multiplier variants.

Test Plan:
- Unsigned, defaults: IN1=0xFF, IN2=0xF, SGN=0 → P=0xEF1 (3825); OUT_VALID exactly 3 cycles after accept.
- Signed extremes: IN1=0x80, IN2=0x8, SGN=1 → P=0x400 (+1024). IN1=0x7F, IN2=0xF, SGN=1 → P=0xF81 (−127). IN1=0x00, IN2=any → P=0.
- Backpressure: OUT_READY=0 for 5 cycles after OUT_VALID → P/OUT_VALID stable, IN_READY=0, a new IN_VALID is not accepted. Raise OUT_READY → handshake in one cycle.
- Back-to-back: IN_VALID and OUT_READY tied high, streaming 0x03×0x5, 0x10×0x2, 0xFF×0x1 → products 0x00F, 0x020, 0x0FF in order, spaced 4 cycles apart.
- Reset mid-op: assert RST_N low during ACCUM → OUT_VALID=0 and P=0 immediately; no result emitted after release; IN_READY=1 next edge.
- Parameter sweep: (N,M,R,BLK) = (16,8,4,4), (8,4,1,1), (12,6,6,5), with 2000 random operands each, both SGN values → match the reference model; latency = M/R+1.
